// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch stage with side-loaded imem, PC and registered output slot
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   load_en/load_addr/load_data  imem write port, usable in every state
//   start                        leave IDLE and begin fetching
//   redirect_valid/redirect_pc   replace PC and squash the output slot (RUN/HALT only)
//   out_valid/out_ready          output slot handshake
//   instr/pc_out                 fetched word and its address
//   halted                       high while stopped on a zero word or end of memory
//   fetch_count                  accepted transfers; built only with IFETCH_PERF_COUNT_EN
module ifetch_stage #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [63:0] PC_RESET   = 64'h0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    input  logic                          start,
    input  logic                          redirect_valid,
    input  logic [63:0]                   redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   instr,
    output logic [63:0]                   pc_out,
    output logic                          halted,
    output logic [31:0]                   fetch_count
);

    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [63:0] pc;
    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] w;
    logic        in_range;
    logic        slot_free;
    logic        do_fetch, do_halt, do_redirect;

    // Asynchronous read: a same-edge load lands after this value is captured,
    // so the fetch sees the old word.
    assign w         = imem[pc[AW+1:2]];
    assign in_range  = (pc[63:AW+2] == '0);
    assign slot_free = !out_valid || out_ready;
    assign halted    = (state == HALT);

    always_ff @(posedge clk) begin
        if (load_en) begin
            imem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        do_fetch    = 1'b0;
        do_halt     = 1'b0;
        do_redirect = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    do_redirect = 1'b1;
                end else if (slot_free) begin
                    if (!in_range || w == 32'h0) begin
                        do_halt    = 1'b1;
                        state_next = HALT;
                    end else begin
                        do_fetch = 1'b1;
                    end
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    do_redirect = 1'b1;
                    state_next  = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= PC_RESET;
            out_valid <= 1'b0;
            instr     <= 32'h0;
            pc_out    <= 64'h0;
        end else if (do_redirect) begin
            // Masking keeps every redirect_pc bit in use while forcing word alignment.
            pc        <= redirect_pc & ~64'h3;
            out_valid <= 1'b0;
        end else if (do_fetch) begin
            instr     <= w;
            pc_out    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + 64'd4;
        end else if (do_halt) begin
            out_valid <= 1'b0;
        end
    end

`ifdef IFETCH_PERF_COUNT_EN
    logic [31:0] count_q;

    // A squashed slot is never counted, even with out_ready high.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 32'h0;
        end else if (out_valid && out_ready && !do_redirect) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - directed scoreboard bench for ifetch_stage
module tb_ifetch_stage;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;
    logic          start = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [63:0]   redirect_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   instr;
    logic [63:0]   pc_out;
    logic          halted;
    logic [31:0]   fetch_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_count = 0;
    logic [95:0] sb [$];

    ifetch_stage #(.IMEM_DEPTH(DEPTH), .PC_RESET(64'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instr          (instr),
        .pc_out         (pc_out),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_fc();
`ifdef IFETCH_PERF_COUNT_EN
        return exp_count;
`else
        return 32'h0;
`endif
    endfunction

    // Inputs are already settled here; a transfer about to happen is popped
    // from the scoreboard and checked before the edge.
    task automatic tick();
        logic [95:0] e;
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("pc_out", pc_out, e[95:32]);
                chk("instr", {32'h0, instr}, {32'h0, e[31:0]});
            end
            exp_count++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = addr[AW-1:0];
        load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_count = 0;
        sb.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [63:0] p, input logic [31:0] w);
        sb.push_back({p, w});
    endtask

    task automatic run_until_halted(input int max);
        for (int i = 0; i < max && !halted; i++) tick();
        chk("halt_reached", {63'h0, halted}, 64'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, {63'h0, out_valid}, 64'd0);
        chk({tag, "_instr"}, {32'h0, instr}, 64'd0);
        chk({tag, "_pc_out"}, pc_out, 64'd0);
        chk({tag, "_halted"}, {63'h0, halted}, 64'd0);
        chk({tag, "_fetch_count"}, {32'h0, fetch_count}, 64'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;

        // Basic stream
        load_word(0, 32'h00500293);
        load_word(1, 32'h00630313);
        load_word(2, 32'h00000000);
        do_reset();
        out_ready = 1'b1;
        push(64'h0, 32'h00500293);
        push(64'h4, 32'h00630313);
        do_start();
        chk("start_no_valid_yet", {63'h0, out_valid}, 64'd0);
        tick();
        chk("first_valid", {63'h0, out_valid}, 64'd1);
        run_until_halted(20);
        chk("basic_out_valid", {63'h0, out_valid}, 64'd0);
        chk("basic_sb_empty", sb.size(), 64'd0);
        chk("basic_fetch_count", {32'h0, fetch_count}, {32'h0, exp_fc()});

        // Backpressure
        do_reset();
        out_ready = 1'b0;
        do_start();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {63'h0, out_valid}, 64'd1);
            chk("bp_instr", {32'h0, instr}, 64'h00500293);
            chk("bp_pc_out", pc_out, 64'h0);
            tick();
        end
        push(64'h0, 32'h00500293);
        push(64'h4, 32'h00630313);
        out_ready = 1'b1;
        run_until_halted(20);
        chk("bp_sb_empty", sb.size(), 64'd0);
        chk("bp_fetch_count", {32'h0, fetch_count}, {32'h0, exp_fc()});

        // Redirect
        for (int i = 0; i < 8; i++) load_word(i, 32'h1000_0000 | i);
        load_word(8, 32'h0);
        do_reset();
        out_ready = 1'b1;
        push(64'h0, 32'h1000_0000);
        push(64'h4, 32'h1000_0001);
        do_start();
        tick();
        tick();
        tick();
        chk("rd_pre_valid", {63'h0, out_valid}, 64'd1);
        chk("rd_pre_pc_out", pc_out, 64'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h13;
        tick();
        redirect_valid = 1'b0;
        chk("rd_squash_valid", {63'h0, out_valid}, 64'd0);
        chk("rd_squash_count", {32'h0, fetch_count}, {32'h0, exp_fc()});
        for (int i = 4; i < 8; i++) push(64'(4 * i), 32'h1000_0000 | i);
        tick();
        chk("rd_new_pc_out", pc_out, 64'h10);
        run_until_halted(20);
        chk("rd_sb_empty", sb.size(), 64'd0);
        chk("rd_fetch_count", {32'h0, fetch_count}, {32'h0, exp_fc()});

        // End of memory
        for (int i = 0; i < DEPTH; i++) load_word(i, 32'hA000_0000 | i);
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) push(64'(4 * i), 32'hA000_0000 | i);
        do_start();
        run_until_halted(200);
        chk("eom_out_valid", {63'h0, out_valid}, 64'd0);
        chk("eom_sb_empty", sb.size(), 64'd0);
        chk("eom_last_pc_out", pc_out, 64'hFC);
        chk("eom_fetch_count", {32'h0, fetch_count}, {32'h0, exp_fc()});
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0;
        out_ready      = 1'b0;
        tick();
        redirect_valid = 1'b0;
        chk("eom_resume_halted", {63'h0, halted}, 64'd0);
        tick();
        chk("eom_resume_valid", {63'h0, out_valid}, 64'd1);
        chk("eom_resume_pc_out", pc_out, 64'h0);
        chk("eom_resume_instr", {32'h0, instr}, 64'hA000_0000);

        // Reset in the middle of a stalled transfer
        tick();
        chk("stall_valid", {63'h0, out_valid}, 64'd1);
        do_reset();
        chk_reset_vals("mid_stall");
        tick();
        chk("idle_no_fetch", {63'h0, out_valid}, 64'd0);
        do_start();
        tick();
        chk("imem_kept_valid", {63'h0, out_valid}, 64'd1);
        chk("imem_kept_instr", {32'h0, instr}, 64'hA000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction fetch stage sitting directly upstream of the I-type execute datapath. Holds a word-addressed instruction memory loaded through a side port, a 64-bit program counter, and a registered output slot that presents one 32-bit instruction plus its PC per transfer over a valid/ready handshake. Supports an execute-side PC redirect and stops cleanly on an all-zero word or when the PC runs past the end of memory.

## Interface
Parameters:
- IMEM_DEPTH, 64: instruction memory depth in 32-bit words; power of two, 4..1024.
- PC_RESET, 64'h0: PC value loaded on reset; word-aligned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  write imem[load_addr] <= load_data this edge.
- load_addr  in  log2(IMEM_DEPTH)  word index for the load port.
- load_data  in  32  instruction word to store.
- start  in  1  begin fetching; honoured only in IDLE.
- redirect_valid  in  1  replace PC and squash the output slot.
- redirect_pc  in  64  new fetch address; bits [1:0] ignored (treated as 0).
- out_valid  out  1  output slot holds an instruction.
- out_ready  in  1  downstream accepts the slot this cycle.
- instr  out  32  fetched instruction; drives the execute stage's instruction input.
- pc_out  out  64  address of instr.
- halted  out  1  high while in HALT.
- fetch_count  out  32  number of accepted transfers.

## Operation
- State machine: IDLE, RUN, HALT. Reset enters IDLE.
- IDLE -> RUN on start. RUN -> HALT on halt condition. HALT -> RUN only on redirect_valid. start is ignored in RUN/HALT.
- Transfer: accepted on any edge where out_valid && out_ready.
- Slot free: !out_valid || out_ready.
- In RUN with slot free and no redirect: read w = imem[pc[log2(IMEM_DEPTH)+1:2]].
  - If pc >= 4*IMEM_DEPTH or w == 32'h0: no load, out_valid <= 0, and the state goes to HALT. The PC is unchanged.
  - Otherwise: instr <= w, pc_out <= pc, out_valid <= 1, pc <= pc + 4.
- In RUN with slot not free: instr, pc_out, out_valid and pc all hold.
- Redirect, valid in RUN or HALT:
  - pc <= {redirect_pc[63:2], 2'b00}, out_valid <= 0, and the state goes to RUN.
  - No fetch happens on that edge.
  - The squashed slot does not count as a transfer, even if out_ready is high.
  - Redirect in IDLE is ignored.
- Load port: active in every state. If the load writes the word being fetched on the same edge, the fetch captures the old contents; the new word is seen on the next fetch.
- imem is not cleared by rst.
- PC arithmetic: unsigned 64-bit, wraps modulo 2^64. Out-of-range halt triggers first in practice.
- fetch_count increments by 1 per accepted transfer and wraps at 2^32.

## Timing
- Reset values: out_valid=0, instr=32'h0, pc_out=64'h0, halted=0, fetch_count=0, pc=PC_RESET, state=IDLE.
- rst has priority over every other input, including in the middle of a stalled transfer. Any pending slot is dropped.
- Start-to-first-valid: start sampled at edge N, RUN at N, out_valid=1 after edge N+1.
- Throughput: one instruction per cycle while out_ready is held high.
- Redirect latency: redirect at edge N gives out_valid=0 after N. The first instruction from the new PC is valid after edge N+1.
- halted rises on the edge that detects the halt condition.
- out_valid and instr are registered. No combinational path from out_ready or redirect_valid to any output.
- While out_valid && !out_ready, instr and pc_out stay stable until the transfer or a redirect.

## Configuration
- IFETCH_PERF_COUNT_EN defined: fetch_count is implemented as described.
- IFETCH_PERF_COUNT_EN undefined: no counter register is built, and fetch_count is tied to 32'h0.
- All other behaviour is identical in both builds.

## Test plan
- Basic stream:
  - Stimulus: load words 0..2 = 32'h00500293, 32'h00630313, 32'h00000000; rst; start; out_ready=1.
  - Response: pc_out 0 then 4, with instr 32'h00500293 then 32'h00630313. halted=1 on the third fetch. fetch_count=2.
- Backpressure:
  - Stimulus: same program, out_ready=0 for 3 cycles after the first valid.
  - Response: instr holds 32'h00500293 with pc_out=0 for 3 cycles, then the stream continues with no loss or duplication.
- Redirect:
  - Stimulus: in RUN with a slot valid at pc_out=8, assert redirect_valid with redirect_pc=64'h13 while out_ready=1.
  - Response: out_valid=0 the next cycle, next pc_out=64'h10, fetch_count not incremented for the squashed slot.
- End of memory:
  - Stimulus: IMEM_DEPTH=64 with all words nonzero; run freely.
  - Response: last pc_out=64'hFC, then halted=1 and out_valid=0. A redirect to 0 resumes at pc_out=0.
- Reset mid-stall:
  - Stimulus: out_valid=1, out_ready=0, then assert rst for 1 cycle.
  - Response: all outputs take their reset values, state is IDLE. Imem contents survive: after start, instr equals the previously loaded word 0.
- Build without IFETCH_PERF_COUNT_EN:
  - Stimulus: rerun the basic stream.
  - Response: same instr/pc_out sequence, fetch_count=0 throughout.
